// File: rtl/ram_block_mover.sv
// ---------------------------------------------------------------------------
// ram_block_mover
//
// Initiator-side block mover for a single-port RAM (12-bit address, 16-bit
// data, combinational read, write on the clock edge where load=1).  It either
// copies a block of words from src to dst, or fills a block at dst with a
// constant.  While busy=1 the engine owns the RAM port. A copy moves one word
// every two cycles (READ then WRITE). A fill writes one word per cycle.
//
// Ports
//   clk          in   1   system clock, all state on the rising edge
//   reset        in   1   synchronous, active-high reset
//   start        in   1   transfer request, sampled only in IDLE
//   mode         in   1   0 = copy src->dst, 1 = fill dst with fill_val
//   src          in   AW  copy source base address (ignored for fill)
//   dst          in   AW  destination base address
//   len          in   LW  word count; 0 is legal, values above 2**AW clamp
//   fill_val     in   DW  fill constant
//   busy         out  1   high while in READ or WRITE
//   done         out  1   one-cycle pulse when a transfer ends
//   count        out  LW  words written so far in the current/last transfer
//   mem_address  out  AW  RAM address
//   mem_in       out  DW  RAM write data
//   mem_load     out  1   RAM write enable
//   mem_out      in   DW  RAM read data (combinational from mem_address)
//   dbg_state_o  out  2   current FSM state, for checkers and debug
//
// Handshake: start is a level sampled on the rising edge while the engine is
// IDLE. Requests seen in READ, WRITE or DONE are dropped, not queued. The
// transfer parameters are captured on the accepting edge, so the requester
// may change them afterwards. Completion is signalled by a single-cycle done
// pulse, which is followed by IDLE.
//
// Every output is decoded from registered state, so no path exists from an
// input port to an output port.
// ---------------------------------------------------------------------------
module ram_block_mover #(
    parameter int AW = 12,
    parameter int DW = 16,
    parameter int LW = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] count,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_in,
    output logic          mem_load,
    input  logic [DW-1:0] mem_out,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Largest legal transfer: the whole address space.
    localparam logic [LW-1:0] MAX_LEN = LW'(1 << AW);

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic [AW-1:0] src_ptr_q, src_ptr_d;
    logic [AW-1:0] dst_ptr_q, dst_ptr_d;
    logic [LW-1:0] remaining_q, remaining_d;
    logic [LW-1:0] count_q, count_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [DW-1:0] data_q, data_d;
    // Address driven on the most recent READ/WRITE cycle. It is held on
    // the bus while IDLE or DONE so the RAM address does not glitch
    // between transfers.
    logic [AW-1:0] last_addr_q, last_addr_d;

    logic [LW-1:0] len_clamped;

    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            fill_q      <= '0;
            data_q      <= '0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            fill_q      <= fill_d;
            data_q      <= data_d;
            last_addr_q <= last_addr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        fill_d      = fill_q;
        data_d      = data_q;
        last_addr_d = last_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    src_ptr_d   = src;
                    dst_ptr_d   = dst;
                    fill_d      = fill_val;
                    remaining_d = len_clamped;
                    count_d     = '0;
                    if (len_clamped == '0) begin
                        state_d = S_DONE;
                    end else if (mode) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end

            S_READ: begin
                data_d      = mem_out;
                last_addr_d = src_ptr_q;
                state_d     = S_WRITE;
            end

            S_WRITE: begin
                // Pointers wrap silently at the top of the address space.
                src_ptr_d   = src_ptr_q + AW'(1);
                dst_ptr_d   = dst_ptr_q + AW'(1);
                remaining_d = remaining_q - LW'(1);
                count_d     = count_q + LW'(1);
                last_addr_d = dst_ptr_q;
                if (remaining_q == LW'(1)) begin
                    state_d = S_DONE;
                end else if (mode_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode (registered state only)
    // -----------------------------------------------------------------------
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        mem_load    = 1'b0;
        mem_in      = '0;
        mem_address = last_addr_q;

        unique case (state_q)
            S_READ: begin
                busy        = 1'b1;
                mem_address = src_ptr_q;
            end
            S_WRITE: begin
                busy        = 1'b1;
                mem_load    = 1'b1;
                mem_address = dst_ptr_q;
                mem_in      = mode_q ? fill_q : data_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign count       = count_q;
    assign dbg_state_o = state_q;

endmodule
